// File: rtl/and_term_stim_if.sv
// rtl/and_term_stim_if.sv - request handshake bundle for the AND-term stimulus block
//
// Purpose: carries the term request from the requester into and_term_stim.
// Signals:
//   req_valid  requester -> block  request present
//   req_term   requester -> block  term number (1..6 legal)
//   req_ready  block -> requester  block can accept a request
interface and_term_stim_if;
  logic       req_valid;
  logic [2:0] req_term;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_term,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_term,
    output req_ready
  );
endinterface

// File: rtl/and_term_stim.sv
// rtl/and_term_stim.sv - stimulus generator and self-checker for AND product-term detectors
//
// Purpose: on an accepted request drives the pattern that makes exactly the
// requested term true, holds it HOLD_CYCLES cycles, then compares the looped
// back detector outputs with the expected one-hot value.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_if         request handshake (slave side)
//   vec_o          driven pattern {X,Y,Z,K,M}, X = bit 4
//   vec_valid_o    vec_o holds a test pattern
//   term_obs_i     detector outputs, bit0 = out_1 .. bit5 = out_6
//   done_o         one-cycle pulse when a check completes
//   pass_o         check result, meaningful only with done_o
//   err_cnt_o      saturating count of failed checks
//   err_sticky_o   set by any failed check until reset
//   bad_req_o      one-cycle pulse after an illegal term is accepted
module and_term_stim #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  and_term_stim_if.slave   req_if,
  output logic [4:0]       vec_o,
  output logic             vec_valid_o,
  input  logic [5:0]       term_obs_i,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             err_sticky_o,
  output logic             bad_req_o
);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [5:0]       exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             bad_req_q, bad_req_d;

  logic       accept;
  logic       legal;
  logic [4:0] rom_vec;
  logic [5:0] rom_exp;

  // Pattern ROM: don't-care bits are picked so no other term aliases true.
  always_comb begin
    rom_vec = '0;
    rom_exp = '0;
    case (req_if.req_term)
      3'd1: begin rom_vec = 5'h0F; rom_exp = 6'b000001; end
      3'd2: begin rom_vec = 5'h06; rom_exp = 6'b000010; end
      3'd3: begin rom_vec = 5'h12; rom_exp = 6'b000100; end
      3'd4: begin rom_vec = 5'h02; rom_exp = 6'b001000; end
      3'd5: begin rom_vec = 5'h00; rom_exp = 6'b010000; end
      3'd6: begin rom_vec = 5'h19; rom_exp = 6'b100000; end
      default: ;
    endcase
  end

  assign legal  = (req_if.req_term != 3'd0) && (req_if.req_term != 3'd7);
  assign accept = req_if.req_valid && req_if.req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      mismatch_q   <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      bad_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      exp_q        <= exp_d;
      cnt_q        <= cnt_d;
      mismatch_q   <= mismatch_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      bad_req_q    <= bad_req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    exp_d        = exp_q;
    cnt_d        = cnt_q;
    mismatch_d   = mismatch_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    bad_req_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            vec_d   = rom_vec;
            exp_d   = rom_exp;
            cnt_d   = CNT_LOAD;
            state_d = DRIVE;
          end else begin
            bad_req_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        // Counter reaching zero marks the last hold cycle: sample and leave.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mismatch_d = (term_obs_i != exp_q);
          state_d    = RESULT;
        end
      end
      RESULT: begin
        state_d = IDLE;
        if (mismatch_q) begin
          err_sticky_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vec is gated by state so it drops to zero as soon as DRIVE ends.
  always_comb begin
    req_if.req_ready = (state_q == IDLE) && !rst;
    vec_valid_o      = (state_q == DRIVE);
    vec_o            = (state_q == DRIVE) ? vec_q : 5'h00;
    done_o           = (state_q == RESULT);
    pass_o           = (state_q == RESULT) && !mismatch_q;
  end

  assign err_cnt_o    = err_cnt_q;
  assign err_sticky_o = err_sticky_q;
  assign bad_req_o    = bad_req_q;
endmodule
